// File: rtl/dual_mem_arb_pkg.sv
// Shared helpers for the dual-port RAM arbiter slice.
package dual_mem_arb_pkg;

    // Stored word is the encoded payload plus one extra bit.
    function automatic int word_w(input int dataWidth);
        return dataWidth + $clog2(dataWidth) + 2;
    endfunction

endpackage

// File: rtl/arb_delay_line.sv
// Resettable shift register; DEPTH=0 degenerates to a wire.
module arb_delay_line #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o
);

    generate
        if (DEPTH == 0) begin : g_pass
            logic unusedSink;
            assign unusedSink = clk ^ rst;
            assign data_o     = data_i;
        end else begin : g_shift
            logic [WIDTH-1:0] stage_q [DEPTH];

            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        stage_q[i] <= '0;
                    end
                end else begin
                    stage_q[0] <= data_i;
                    for (int i = 1; i < DEPTH; i++) begin
                        stage_q[i] <= stage_q[i-1];
                    end
                end
            end

            assign data_o = stage_q[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/dual_mem_port_arbiter.sv
// Round-robin arbiter sharing one port of the latency RAM between NUM_REQ requesters,
// with delayed write controls, tagged read returns and read-after-write stalling.
module dual_mem_port_arbiter
    import dual_mem_arb_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int DATA_WIDTH = 8,
    parameter int MEM_DEPTH  = 16,
    parameter int ADDR_WIDTH = $clog2(MEM_DEPTH),
    parameter int WR_LATENCY = 1,
    parameter int RD_LATENCY = 1,
    localparam int WORD_W    = word_w(DATA_WIDTH)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            i_req_valid,
    output logic [NUM_REQ-1:0]            o_req_ready,
    input  logic [NUM_REQ-1:0]            i_req_we,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] i_req_addr,
    input  logic [NUM_REQ*WORD_W-1:0]     i_req_wdata,
    output logic [NUM_REQ-1:0]            o_rsp_valid,
    output logic [WORD_W-1:0]             o_rsp_rdata,
    output logic                          o_mem_en_wr,
    output logic                          o_mem_we,
    output logic [ADDR_WIDTH-1:0]         o_mem_addr_wr,
    output logic [WORD_W-1:0]             o_mem_din,
    output logic                          o_mem_en_rd,
    output logic                          o_mem_rd,
    output logic [ADDR_WIDTH-1:0]         o_mem_addr_rd,
    input  logic [WORD_W-1:0]             i_mem_dout
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef struct packed {
        logic                  valid;
        logic [ADDR_WIDTH-1:0] addr;
        logic [WORD_W-1:0]     data;
    } wr_entry_t;

    typedef struct packed {
        logic               valid;
        logic [NUM_REQ-1:0] id;
    } rd_tag_t;

    logic [PTR_W-1:0]      rrPtr_q, rrPtr_d;
    logic [NUM_REQ-1:0]    blocked, eligible, grantOh;
    logic                  anyGrant, grantWe, rdEn;
    logic [ADDR_WIDTH-1:0] grantAddr;
    logic [WORD_W-1:0]     grantData, rdData;
    wr_entry_t             wrNew, wrOut;
    wr_entry_t             wrStage [WR_LATENCY];
    rd_tag_t               tagIn, tagOut;

    // Stages 1..WR_LATENCY-1 hold writes the array has not absorbed yet.
    always_comb begin
        blocked = '0;
        for (int r = 0; r < NUM_REQ; r++) begin
            for (int k = 1; k < WR_LATENCY; k++) begin
                if (!i_req_we[r] && wrStage[k].valid &&
                    wrStage[k].addr == i_req_addr[r*ADDR_WIDTH +: ADDR_WIDTH]) begin
                    blocked[r] = 1'b1;
                end
            end
        end
    end

    assign eligible = i_req_valid & ~blocked & {NUM_REQ{!rst}};

    // Two passes: indices at/after the pointer first, then wrap from 0.
    always_comb begin
        grantOh  = '0;
        anyGrant = 1'b0;
        rrPtr_d  = rrPtr_q;
        for (int r = 0; r < NUM_REQ; r++) begin
            if (!anyGrant && eligible[r] && r >= int'(rrPtr_q)) begin
                grantOh[r] = 1'b1;
                anyGrant   = 1'b1;
                rrPtr_d    = (r == NUM_REQ - 1) ? '0 : PTR_W'(r + 1);
            end
        end
        for (int r = 0; r < NUM_REQ; r++) begin
            if (!anyGrant && eligible[r]) begin
                grantOh[r] = 1'b1;
                anyGrant   = 1'b1;
                rrPtr_d    = (r == NUM_REQ - 1) ? '0 : PTR_W'(r + 1);
            end
        end
        grantWe   = 1'b0;
        grantAddr = '0;
        grantData = '0;
        for (int r = 0; r < NUM_REQ; r++) begin
            if (grantOh[r]) begin
                grantWe   = i_req_we[r];
                grantAddr = i_req_addr[r*ADDR_WIDTH +: ADDR_WIDTH];
                grantData = i_req_wdata[r*WORD_W +: WORD_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rrPtr_q <= '0;
        end else begin
            rrPtr_q <= rrPtr_d;
        end
    end

    assign rdEn  = anyGrant && !grantWe;
    assign wrNew = '{valid: anyGrant && grantWe, addr: grantAddr, data: grantData};
    assign tagIn = '{valid: rdEn, id: rdEn ? grantOh : '0};

    assign wrStage[0] = wrNew;
    generate
        for (genvar k = 1; k < WR_LATENCY; k++) begin : g_wr_pipe
            arb_delay_line #(.WIDTH($bits(wr_entry_t)), .DEPTH(1)) u_wr_stage (
                .clk    (clk),
                .rst    (rst),
                .data_i (wrStage[k-1]),
                .data_o (wrStage[k])
            );
        end
    endgenerate
    assign wrOut = wrStage[WR_LATENCY-1];

    arb_delay_line #(.WIDTH($bits(rd_tag_t)), .DEPTH(RD_LATENCY)) u_rd_tag (
        .clk    (clk),
        .rst    (rst),
        .data_i (tagIn),
        .data_o (tagOut)
    );

    // RAM data already lags the grant by one cycle, so it needs one stage fewer.
    arb_delay_line #(.WIDTH(WORD_W), .DEPTH(RD_LATENCY - 1)) u_rd_data (
        .clk    (clk),
        .rst    (rst),
        .data_i (i_mem_dout),
        .data_o (rdData)
    );

    assign o_req_ready   = grantOh;
    assign o_mem_en_wr   = wrOut.valid && !rst;
    assign o_mem_we      = o_mem_en_wr;
    assign o_mem_addr_wr = o_mem_en_wr ? wrOut.addr : '0;
    assign o_mem_din     = o_mem_en_wr ? wrOut.data : '0;
    assign o_mem_en_rd   = rdEn;
    assign o_mem_rd      = 1'b0;
    assign o_mem_addr_rd = rdEn ? grantAddr : '0;
    assign o_rsp_valid   = (tagOut.valid && !rst) ? tagOut.id : '0;
    assign o_rsp_rdata   = (tagOut.valid && !rst) ? rdData : '0;

endmodule
